// File: rtl/rtc_write_seq.sv
// rtc_write_seq: RTC write-back sequencer.
// Snapshots BCD time, range-checks it, then writes sec/min/hour over the A/D bus.
module rtc_write_seq #(
    parameter logic [7:0] ADDR_SEG = 8'h21,
    parameter logic [7:0] ADDR_MIN = 8'h22,
    parameter logic [7:0] ADDR_HOR = 8'h23,
    parameter int         T_SU     = 2,
    parameter int         T_WR     = 4,
    parameter int         T_H      = 2,
    parameter int         T_GAP    = 3
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       START,
    input  logic [7:0] DATA_SEG,
    input  logic [7:0] DATA_MIN,
    input  logic [7:0] DATA_HOR,
    output logic [7:0] AD_out,
    output logic       AD_oe,
    output logic       AD_sel,
    output logic       CS_n,
    output logic       RD_n,
    output logic       WR_n,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR
);

    typedef enum logic [2:0] {
        IDLE, CHECK, SETUP, STROBE, HOLD, GAP, FINISH
    } state_t;

    localparam int TM1  = (T_SU > T_WR) ? T_SU : T_WR;
    localparam int TM2  = (T_H > T_GAP) ? T_H : T_GAP;
    localparam int TMAX = (TM1 > TM2) ? TM1 : TM2;
    localparam int CW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    state_t         state, nxt;
    logic [CW-1:0]  cnt, cnt_d;
    logic [1:0]     idx, idx_d;
    logic           phase, phase_d;
    logic [7:0]     s_seg, s_min, s_hor;
    logic [7:0]     seg_d, min_d, hor_d;
    logic [7:0]     out_d, byte_d;
    logic           oe_d, sel_d, cs_d, wr_d, busy_d, done_d, err_d;

    function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] lim);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= lim);
    endfunction

    function automatic logic [CW-1:0] load(input state_t s);
        logic [CW-1:0] r;
        r = '0;
        unique case (s)
            SETUP:   r = CW'(T_SU - 1);
            STROBE:  r = CW'(T_WR - 1);
            HOLD:    r = CW'(T_H - 1);
            GAP:     r = CW'(T_GAP - 1);
            default: r = '0;
        endcase
        return r;
    endfunction

    assign RD_n = 1'b1;

    // Next state, sequencing counters and next registered outputs
    always_comb begin
        nxt     = state;
        idx_d   = idx;
        phase_d = phase;
        seg_d   = s_seg;
        min_d   = s_min;
        hor_d   = s_hor;
        err_d   = 1'b0;

        unique case (state)
            IDLE: begin
                if (START) begin
                    seg_d = DATA_SEG;
                    min_d = DATA_MIN;
                    hor_d = DATA_HOR;
                    idx_d = 2'd0;
                    nxt   = CHECK;
                end
            end
            CHECK: begin
                if (bcd_ok(s_seg, 8'h59) && bcd_ok(s_min, 8'h59) &&
                    bcd_ok(s_hor, 8'h23)) begin
                    phase_d = 1'b0;
                    nxt     = SETUP;
                end else begin
                    err_d = 1'b1;
                    nxt   = IDLE;
                end
            end
            SETUP:  if (cnt == '0) nxt = STROBE;
            STROBE: if (cnt == '0) nxt = HOLD;
            HOLD: begin
                if (cnt == '0) begin
                    if (!phase) begin
                        phase_d = 1'b1;
                        nxt     = SETUP;
                    end else begin
                        nxt = GAP;
                    end
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    idx_d = idx + 2'd1;
                    if (idx == 2'd2) begin
                        nxt = FINISH;
                    end else begin
                        phase_d = 1'b0;
                        nxt     = SETUP;
                    end
                end
            end
            FINISH:  nxt = IDLE;
            default: nxt = IDLE;
        endcase

        if (nxt != state)
            cnt_d = load(nxt);
        else if (cnt != '0)
            cnt_d = cnt - 1'b1;
        else
            cnt_d = cnt;

        if (phase_d) begin
            unique case (idx_d)
                2'd0:    byte_d = seg_d;
                2'd1:    byte_d = min_d;
                default: byte_d = hor_d;
            endcase
        end else begin
            unique case (idx_d)
                2'd0:    byte_d = ADDR_SEG;
                2'd1:    byte_d = ADDR_MIN;
                default: byte_d = ADDR_HOR;
            endcase
        end

        out_d  = 8'h00;
        oe_d   = 1'b0;
        sel_d  = 1'b0;
        cs_d   = 1'b1;
        wr_d   = 1'b1;
        busy_d = 1'b0;
        done_d = 1'b0;
        unique case (nxt)
            SETUP, STROBE, HOLD: begin
                out_d  = byte_d;
                oe_d   = 1'b1;
                sel_d  = phase_d;
                cs_d   = 1'b0;
                wr_d   = (nxt != STROBE);
                busy_d = 1'b1;
            end
            GAP:     busy_d = 1'b1;
            FINISH:  done_d = 1'b1;
            default: busy_d = 1'b0;
        endcase
    end

    // State, snapshot, counters and output registers
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= 2'd0;
            phase  <= 1'b0;
            s_seg  <= 8'h00;
            s_min  <= 8'h00;
            s_hor  <= 8'h00;
            AD_out <= 8'h00;
            AD_oe  <= 1'b0;
            AD_sel <= 1'b0;
            CS_n   <= 1'b1;
            WR_n   <= 1'b1;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
            ERR    <= 1'b0;
        end else begin
            state  <= nxt;
            cnt    <= cnt_d;
            idx    <= idx_d;
            phase  <= phase_d;
            s_seg  <= seg_d;
            s_min  <= min_d;
            s_hor  <= hor_d;
            AD_out <= out_d;
            AD_oe  <= oe_d;
            AD_sel <= sel_d;
            CS_n   <= cs_d;
            WR_n   <= wr_d;
            BUSY   <= busy_d;
            DONE   <= done_d;
            ERR    <= err_d;
        end
    end

endmodule

// File: tb/tb_rtc_write_seq.sv
// tb_rtc_write_seq: directed bench for rtc_write_seq.
// Runs a default-timing and a minimum-timing instance side by side.
module tb_rtc_write_seq;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic       START;
    logic [7:0] DATA_SEG, DATA_MIN, DATA_HOR;

    logic [7:0] ad_out [2];
    logic       ad_oe  [2];
    logic       ad_sel [2];
    logic       cs_n   [2];
    logic       rd_n   [2];
    logic       wr_n   [2];
    logic       busy   [2];
    logic       done   [2];
    logic       err    [2];

    int vec = 0;
    int miscmp = 0;
    int cyc = 0;
    int st = 0;

    logic [8:0] byt   [2][8];
    int         wf    [2][8];
    int         wl    [2][8];
    int         nb    [2];
    int         wcnt  [2];
    int         csf   [2];
    int         donec [2];
    int         donecyc [2];
    int         errc  [2];
    int         errcyc [2];
    logic       busy_seen [2];
    logic       bus_act [2];
    logic       busy_at_done [2];
    logic       pwr [2];
    logic       pcs [2];

    // Free-running clock
    always #5 CLK = ~CLK;

    rtc_write_seq u_dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START),
        .DATA_SEG(DATA_SEG), .DATA_MIN(DATA_MIN), .DATA_HOR(DATA_HOR),
        .AD_out(ad_out[0]), .AD_oe(ad_oe[0]), .AD_sel(ad_sel[0]),
        .CS_n(cs_n[0]), .RD_n(rd_n[0]), .WR_n(wr_n[0]),
        .BUSY(busy[0]), .DONE(done[0]), .ERR(err[0])
    );

    rtc_write_seq #(.T_SU(1), .T_WR(1), .T_H(1), .T_GAP(1)) u_fast (
        .CLK(CLK), .RESET_N(RESET_N), .START(START),
        .DATA_SEG(DATA_SEG), .DATA_MIN(DATA_MIN), .DATA_HOR(DATA_HOR),
        .AD_out(ad_out[1]), .AD_oe(ad_oe[1]), .AD_sel(ad_sel[1]),
        .CS_n(cs_n[1]), .RD_n(rd_n[1]), .WR_n(wr_n[1]),
        .BUSY(busy[1]), .DONE(done[1]), .ERR(err[1])
    );

    task automatic chk(input string tag, input int got, input int exp);
        vec++;
        if (got !== exp) begin
            miscmp++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        for (int i = 0; i < 2; i++) begin
            nb[i] = 0; wcnt[i] = 0; csf[i] = -1;
            donec[i] = 0; donecyc[i] = 0; errc[i] = 0; errcyc[i] = 0;
            busy_seen[i] = 1'b0; bus_act[i] = 1'b0; busy_at_done[i] = 1'b0;
            pwr[i] = 1'b1; pcs[i] = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (pwr[i] && !wr_n[i]) begin
                if (nb[i] < 8) begin
                    byt[i][nb[i]] = {ad_sel[i], ad_out[i]};
                    wf[i][nb[i]] = cyc;
                end
                nb[i]++;
                wcnt[i] = 0;
            end
            if (!wr_n[i])
                wcnt[i]++;
            else if (!pwr[i] && nb[i] > 0 && nb[i] <= 8)
                wl[i][nb[i]-1] = wcnt[i];
            if (pcs[i] && !cs_n[i] && csf[i] < 0) csf[i] = cyc;
            if (done[i]) begin
                donec[i]++;
                donecyc[i] = cyc;
                busy_at_done[i] = busy[i];
            end
            if (err[i]) begin
                errc[i]++;
                errcyc[i] = cyc;
            end
            if (busy[i]) busy_seen[i] = 1'b1;
            if (!cs_n[i] || !wr_n[i] || ad_oe[i]) bus_act[i] = 1'b1;
            pwr[i] = wr_n[i];
            pcs[i] = cs_n[i];
        end
    endtask

    task automatic start_seq(input logic [7:0] s, input logic [7:0] m,
                             input logic [7:0] h);
        DATA_SEG = s;
        DATA_MIN = m;
        DATA_HOR = h;
        START = 1'b1;
        tick();
        START = 1'b0;
        st = cyc;
    endtask

    task automatic wait_done(input int budget);
        for (int j = 0; j < budget && donec[0] == 0; j++) tick();
    endtask

    task automatic chk_seq(input string tag, input int i, input logic [7:0] s,
                           input logic [7:0] m, input logic [7:0] h,
                           input int wlen, input int txn);
        logic [8:0] e [6];
        e[0] = {1'b0, 8'h21};
        e[1] = {1'b1, s};
        e[2] = {1'b0, 8'h22};
        e[3] = {1'b1, m};
        e[4] = {1'b0, 8'h23};
        e[5] = {1'b1, h};
        chk($sformatf("%s_npulse", tag), nb[i], 6);
        for (int j = 0; j < 6; j++) begin
            chk($sformatf("%s_byte%0d", tag, j), int'(byt[i][j]), int'(e[j]));
            chk($sformatf("%s_wlen%0d", tag, j), wl[i][j], wlen);
        end
        chk($sformatf("%s_txn", tag), wf[i][2] - wf[i][0], txn);
    endtask

    initial begin
        RESET_N = 1'b0;
        START = 1'b0;
        DATA_SEG = 8'h00;
        DATA_MIN = 8'h00;
        DATA_HOR = 8'h00;
        clear_mon();
        tick();
        tick();
        chk("rst_ad_out", int'(ad_out[0]), 0);
        chk("rst_ad_oe", int'(ad_oe[0]), 0);
        chk("rst_ad_sel", int'(ad_sel[0]), 0);
        chk("rst_cs_n", int'(cs_n[0]), 1);
        chk("rst_rd_n", int'(rd_n[0]), 1);
        chk("rst_wr_n", int'(wr_n[0]), 1);
        chk("rst_busy", int'(busy[0]), 0);
        chk("rst_done", int'(done[0]), 0);
        chk("rst_err", int'(err[0]), 0);
        RESET_N = 1'b1;
        tick();

        // Nominal write-back
        clear_mon();
        start_seq(8'h45, 8'h30, 8'h12);
        wait_done(100);
        repeat (3) tick();
        chk("t1_done", donec[0], 1);
        chk("t1_done_lat", donecyc[0] - st, 58);
        chk("t1_cs_to_done", donecyc[0] - csf[0], 57);
        chk("t1_cs_lat", csf[0] - st, 1);
        chk("t1_setup", wf[0][0] - csf[0], 2);
        chk("t1_busy_at_done", int'(busy_at_done[0]), 0);
        chk_seq("t1", 0, 8'h45, 8'h30, 8'h12, 4, 19);
        chk("t1f_done", donec[1], 1);
        chk("t1f_cs_to_done", donecyc[1] - csf[1], 21);
        chk_seq("t1f", 1, 8'h45, 8'h30, 8'h12, 1, 7);

        // Rejected requests
        clear_mon();
        start_seq(8'h12, 8'h5A, 8'h10);
        repeat (4) tick();
        chk("t2a_err", errc[0], 1);
        chk("t2a_err_lat", errcyc[0] - st, 1);
        chk("t2a_bus", int'(bus_act[0]), 0);
        chk("t2a_busy", int'(busy_seen[0]), 0);
        chk("t2a_done", donec[0], 0);
        clear_mon();
        start_seq(8'h12, 8'h30, 8'h24);
        repeat (4) tick();
        chk("t2b_err", errc[0], 1);
        chk("t2b_err_lat", errcyc[0] - st, 1);
        chk("t2b_bus", int'(bus_act[0]), 0);
        chk("t2b_busy", int'(busy_seen[0]), 0);
        chk("t2bf_err", errc[1], 1);

        // Boundary values
        clear_mon();
        start_seq(8'h59, 8'h00, 8'h23);
        wait_done(100);
        repeat (3) tick();
        chk("t3_done", donec[0], 1);
        chk("t3_err", errc[0], 0);
        chk_seq("t3", 0, 8'h59, 8'h00, 8'h23, 4, 19);
        chk_seq("t3f", 1, 8'h59, 8'h00, 8'h23, 1, 7);

        // Re-pulsed START and late data change
        clear_mon();
        start_seq(8'h11, 8'h22, 8'h05);
        repeat (5) tick();
        DATA_MIN = 8'h33;
        START = 1'b1;
        repeat (3) tick();
        START = 1'b0;
        wait_done(100);
        repeat (80) tick();
        chk("t4_done", donec[0], 1);
        chk("t4f_done", donec[1], 1);
        chk_seq("t4", 0, 8'h11, 8'h22, 8'h05, 4, 19);

        // Reset during minutes data strobe
        clear_mon();
        start_seq(8'h45, 8'h30, 8'h12);
        for (int j = 0; j < 60 && nb[0] < 4; j++) tick();
        chk("t5_reach", nb[0], 4);
        chk("t5_in_strobe", int'(wr_n[0]), 0);
        RESET_N = 1'b0;
        tick();
        chk("t5_wr_n", int'(wr_n[0]), 1);
        chk("t5_cs_n", int'(cs_n[0]), 1);
        chk("t5_ad_oe", int'(ad_oe[0]), 0);
        chk("t5_busy", int'(busy[0]), 0);
        RESET_N = 1'b1;
        clear_mon();
        repeat (80) tick();
        chk("t5_no_done", donec[0], 0);
        chk("t5_no_bus", int'(bus_act[0]), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end

endmodule
